neuron_array_sequencer: RTL
===========================

// Module: neuron_array_sequencer
// PURPOSE
//  Job controller in front of top_neurons: drives its ins/rd bus and array reset, streams host config words into it,
//  runs annealing for a programmed cycle count, then collects the packed neuron_states readout into a result FIFO.
//  Sits between the host/bridge (valid/ready streams) and one top_neurons instance; one job at a time.
// PARAMETERS
//  FP_DATA_WIDTH    16   width of ins/outs/cfg/result words
//  NUM_NEURON       256  neurons in the array
//  NEURON_ID_WIDTH  8    width of the neuron index
//  RUN_CNT_WIDTH    16   width of run_cycles counter
//  RES_DEPTH        32   result FIFO depth, power of 2, >= NUM_NEURON/16+1
// PORTS
//  clk          in   1                clock (array clk shares it)
//  reset_l      in   1                reset, asynchronous, active-low
//  start        in   1                1-cycle pulse: begin job (ignored while busy)
//  num_neurons  in   NEURON_ID_WIDTH  active neuron count, legal 2..NUM_NEURON-1, sampled on start
//  run_cycles   in   RUN_CNT_WIDTH    anneal cycles per sample, sampled on start
//  num_samples  in   4                samples per job (used only with NSA_MULTI_SAMPLE_EN)
//  cfg_valid    in   1                config word valid
//  cfg_ready    out  1                config word accepted when valid&ready
//  cfg_data     in   FP_DATA_WIDTH    config word (Vmem, mu, neuronI, Q per neuron, in that order)
//  arr_reset_l  out  1                sync active-low reset to top_neurons
//  arr_ins      out  FP_DATA_WIDTH    to top_neurons.ins
//  arr_rd       out  1                to top_neurons.rd
//  arr_outs     in   FP_DATA_WIDTH    from top_neurons.outs
//  arr_read_done in  1                from top_neurons.readDone
//  res_valid    out  1                result word valid
//  res_ready    in   1                result word consumed when valid&ready
//  res_data     out  FP_DATA_WIDTH    result word, FIFO head
//  busy         out  1                high in every state except IDLE
//  done         out  1                1-cycle pulse when job finishes (normally or with error)
//  err          out  1                sticky; cleared on next accepted start
// BEHAVIOUR
//  Reset: state IDLE, arr_reset_l=0, arr_ins=0, arr_rd=0, cfg_ready=0, res_valid=0, busy=0, done=0, err=0, FIFO empty.
//  FSM: IDLE -> ARST -> SETN -> ARM -> LOAD -> RUN -> READ -> DRAIN -> IDLE.
//  IDLE: arr_reset_l=1; on start with num_neurons legal -> ARST; illegal -> err=1, done pulse, stay IDLE.
//  ARST: arr_reset_l=0 for exactly 2 cycles, arr_ins=0.
//  SETN: 1 cycle, arr_ins = num_neurons (zero-extended); array latches active count.
//  ARM: 1 cycle, arr_ins = all ones (begin-write token).
//  LOAD: expect num_neurons*4 words; cfg_ready=1; each accepted word driven on arr_ins the same cycle.
//   Array consumes one word per cycle: cfg_valid low in any LOAD cycle = underrun -> err=1, done, -> IDLE.
//   Word counter width NEURON_ID_WIDTH+2; last word accepted -> RUN next cycle. cfg_ready=0 outside LOAD.
//  RUN: arr_rd=0, arr_ins=0; down-counter loaded with run_cycles; -> READ when it reaches 0 (run_cycles=0 -> READ after 1 cycle).
//  READ: arr_rd=1 until arr_read_done seen; capture arr_outs every cycle from the 2nd READ cycle through the
//   arr_read_done cycle inclusive; expected count = (num_neurons>>4)+1. arr_rd drops the cycle after arr_read_done.
//   Capture into full FIFO: word dropped, err=1 (array cannot stall). Count mismatch at arr_read_done -> err=1.
//   No arr_read_done within (NUM_NEURON/16)+4 cycles -> err=1, done, -> IDLE.
//  DRAIN: wait until FIFO empty -> done pulse, -> IDLE. FIFO push/pop same cycle when full or empty both honoured.
//  res_data valid combinationally from FIFO head; res_valid = !empty in any state.
//  start while busy: ignored, no effect on err. Async reset mid-job: immediate return to reset values, FIFO flushed.
// CONFIGURATION
//  NSA_MULTI_SAMPLE_EN defined: after READ completes, if samples taken < num_samples (0 treated as 1) return to RUN
//   without reloading; DRAIN only after last sample. FIFO holds all samples; overflow rules above apply.
//  Not defined: num_samples ignored; exactly one sample per job.
// TESTING
//  num_neurons=32,run_cycles=10, 128 gap-free cfg words -> arr_ins seq 32,FFFF,words; 3 res words; done; err=0.
//  cfg_valid low on LOAD word 5 -> err=1, done pulse, IDLE, cfg_ready=0 next cycle.
//  start with num_neurons=1 -> err=1, done same+1 cycle, arr_reset_l never pulsed.
//  res_ready=0 throughout, num_neurons=200 -> 13 words buffered, err=0, DRAIN holds busy until popped.
//  reset_l low during RUN -> all outputs at reset values that cycle, FIFO empty; new job completes normally.
//  NSA_MULTI_SAMPLE_EN, num_samples=3, num_neurons=16 -> 6 res words, single ARST/LOAD, one done.

Source files
------------

// File: rtl/neuron_array_sequencer.sv
// Job controller for one top_neurons array: reset, configure, anneal, then read back into a result FIFO.
// Optional multi-sample jobs are enabled by defining NSA_MULTI_SAMPLE_EN.
module neuron_array_sequencer #(
  parameter int FP_DATA_WIDTH   = 16,
  parameter int NUM_NEURON      = 256,
  parameter int NEURON_ID_WIDTH = 8,
  parameter int RUN_CNT_WIDTH   = 16,
  parameter int RES_DEPTH       = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_l_i,
  input  logic                       start_i,
  input  logic [NEURON_ID_WIDTH-1:0] num_neurons_i,
  input  logic [RUN_CNT_WIDTH-1:0]   run_cycles_i,
  input  logic [3:0]                 num_samples_i,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  input  logic [FP_DATA_WIDTH-1:0]   cfg_data_i,
  output logic                       arr_reset_l_o,
  output logic [FP_DATA_WIDTH-1:0]   arr_ins_o,
  output logic                       arr_rd_o,
  input  logic [FP_DATA_WIDTH-1:0]   arr_outs_i,
  input  logic                       arr_read_done_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [FP_DATA_WIDTH-1:0]   res_data_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int WORD_CNT_W = NEURON_ID_WIDTH + 2;
  localparam int PTR_W      = $clog2(RES_DEPTH);
  localparam int READ_LIMIT = NUM_NEURON / 16 + 4;
  localparam int RD_CNT_W   = $clog2(READ_LIMIT) + 1;

  typedef enum logic [2:0] {IDLE, ARST, SETN, ARM, LOAD, RUN, READ, DRAIN} state_e;

  state_e                     state_q;
  logic                       arrResetL_q, arrRd_q, cfgReady_q, done_q, err_q, arstSecond_q;
  logic [FP_DATA_WIDTH-1:0]   arrIns_q;
  logic [NEURON_ID_WIDTH-1:0] numNeurons_q, capCnt_q;
  logic [RUN_CNT_WIDTH-1:0]   runCycles_q, runCnt_q;
  logic [WORD_CNT_W-1:0]      wordCnt_q;
  logic [RD_CNT_W-1:0]        readCyc_q;

  logic [FP_DATA_WIDTH-1:0]   fifoMem_q [RES_DEPTH];
  logic [PTR_W:0]             wrPtr_q, rdPtr_q, wrPtr_d, rdPtr_d;

  logic                       numLegal, lastWord, capture, push, pop, overflow;
  logic                       fifoEmpty, fifoFull, moreSamples;
  logic [WORD_CNT_W-1:0]      totalWords;
  logic [NEURON_ID_WIDTH-1:0] expCount, capNext;

  assign numLegal   = (num_neurons_i >= NEURON_ID_WIDTH'(2)) && (32'(num_neurons_i) <= NUM_NEURON - 1);
  assign totalWords = {numNeurons_q, 2'b00};
  assign lastWord   = (wordCnt_q == totalWords - WORD_CNT_W'(1));
  assign expCount   = (numNeurons_q >> 4) + NEURON_ID_WIDTH'(1);

  // The first READ cycle only launches the readout; data is valid from the second cycle on.
  assign capture  = (state_q == READ) && (readCyc_q != '0);
  assign capNext  = capCnt_q + {{(NEURON_ID_WIDTH-1){1'b0}}, capture};
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                     (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign pop      = res_ready_i && !fifoEmpty;
  assign push     = capture && (!fifoFull || pop);
  assign overflow = capture && fifoFull && !pop;

`ifdef NSA_MULTI_SAMPLE_EN
  logic [3:0] numSamples_q, sampleCnt_q;
  logic [4:0] sampleTarget;

  assign sampleTarget = (numSamples_q == 4'd0) ? 5'd1 : {1'b0, numSamples_q};
  assign moreSamples  = ({1'b0, sampleCnt_q} + 5'd1) < sampleTarget;

  always_ff @(posedge clk_i or negedge reset_l_i) begin
    if (!reset_l_i) begin
      numSamples_q <= '0;
      sampleCnt_q  <= '0;
    end else if (state_q == IDLE && start_i && numLegal) begin
      numSamples_q <= num_samples_i;
      sampleCnt_q  <= '0;
    end else if (state_q == READ && arr_read_done_i && moreSamples) begin
      sampleCnt_q <= sampleCnt_q + 4'd1;
    end
  end
`else
  logic unusedNumSamples;
  assign unusedNumSamples = ^num_samples_i;
  assign moreSamples      = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_l_i) begin
    if (!reset_l_i) begin
      state_q      <= IDLE;
      arrResetL_q  <= 1'b0;
      arrIns_q     <= '0;
      arrRd_q      <= 1'b0;
      cfgReady_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      arstSecond_q <= 1'b0;
      numNeurons_q <= '0;
      runCycles_q  <= '0;
      runCnt_q     <= '0;
      wordCnt_q    <= '0;
      readCyc_q    <= '0;
      capCnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (overflow) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          arrResetL_q <= 1'b1;
          arrIns_q    <= '0;
          if (start_i) begin
            if (numLegal) begin
              err_q        <= 1'b0;
              numNeurons_q <= num_neurons_i;
              runCycles_q  <= run_cycles_i;
              arstSecond_q <= 1'b0;
              arrResetL_q  <= 1'b0;
              state_q      <= ARST;
            end else begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        ARST: begin
          if (arstSecond_q) begin
            arrResetL_q <= 1'b1;
            arrIns_q    <= FP_DATA_WIDTH'(numNeurons_q);
            state_q     <= SETN;
          end else begin
            arstSecond_q <= 1'b1;
          end
        end
        SETN: begin
          arrIns_q <= '1;
          state_q  <= ARM;
        end
        ARM: begin
          arrIns_q   <= '0;
          cfgReady_q <= 1'b1;
          wordCnt_q  <= '0;
          state_q    <= LOAD;
        end
        // The array consumes a word every cycle, so any gap aborts the job.
        LOAD: begin
          if (cfg_valid_i) begin
            wordCnt_q <= wordCnt_q + WORD_CNT_W'(1);
            if (lastWord) begin
              cfgReady_q <= 1'b0;
              runCnt_q   <= runCycles_q;
              state_q    <= RUN;
            end
          end else begin
            cfgReady_q <= 1'b0;
            err_q      <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end
        end
        RUN: begin
          if (runCnt_q == '0) begin
            arrRd_q   <= 1'b1;
            readCyc_q <= '0;
            capCnt_q  <= '0;
            state_q   <= READ;
          end else begin
            runCnt_q <= runCnt_q - RUN_CNT_WIDTH'(1);
          end
        end
        READ: begin
          readCyc_q <= readCyc_q + RD_CNT_W'(1);
          capCnt_q  <= capNext;
          if (arr_read_done_i) begin
            arrRd_q <= 1'b0;
            if (capNext != expCount) err_q <= 1'b1;
            if (moreSamples) begin
              runCnt_q <= runCycles_q;
              state_q  <= RUN;
            end else begin
              state_q <= DRAIN;
            end
          end else if (readCyc_q == RD_CNT_W'(READ_LIMIT - 1)) begin
            arrRd_q <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        DRAIN: begin
          if (fifoEmpty) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push) wrPtr_d = wrPtr_q + (PTR_W+1)'(1);
    if (pop)  rdPtr_d = rdPtr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk_i or negedge reset_l_i) begin
    if (!reset_l_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifoMem_q[wrPtr_q[PTR_W-1:0]] <= arr_outs_i;
  end

  assign cfg_ready_o   = cfgReady_q;
  assign arr_reset_l_o = arrResetL_q;
  assign arr_ins_o     = (state_q == LOAD && cfg_valid_i) ? cfg_data_i : arrIns_q;
  assign arr_rd_o      = arrRd_q;
  assign res_valid_o   = !fifoEmpty;
  assign res_data_o    = fifoMem_q[rdPtr_q[PTR_W-1:0]];
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule
